// File: rtl/volatility_buf_sched.sv
// Scheduler for the shared single-port volatility sample RAM: places price samples into
// per-stock circular regions and streams round-robin granted regions oldest-first.
module volatility_buf_sched #(
    parameter int unsigned NUM_STOCKS  = 4,
    parameter int unsigned BUFFER_SIZE = 20,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = $clog2(NUM_STOCKS * BUFFER_SIZE)
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_wr_valid,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_wr_stock_id,
    input  logic [DATA_WIDTH-1:0]         i_wr_data,
    input  logic [NUM_STOCKS-1:0]         i_calc_req,
    output logic [NUM_STOCKS-1:0]         o_calc_ack,
    output logic                          o_mem_we,
    output logic                          o_mem_re,
    output logic [ADDR_WIDTH-1:0]         o_mem_addr,
    output logic [DATA_WIDTH-1:0]         o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]         i_mem_rdata,
    output logic                          o_rd_valid,
    output logic [DATA_WIDTH-1:0]         o_rd_data,
    output logic [$clog2(NUM_STOCKS)-1:0] o_rd_stock_id,
    output logic                          o_rd_last,
    output logic                          o_busy
);

    localparam int unsigned SID_W = $clog2(NUM_STOCKS);
    localparam int unsigned IDX_W = $clog2(BUFFER_SIZE);
    localparam int unsigned CNT_W = $clog2(BUFFER_SIZE + 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   head_q [NUM_STOCKS];
    logic [CNT_W-1:0]   fill_q [NUM_STOCKS];
    logic [SID_W-1:0]   gnt_q, gnt_d;
    logic [SID_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               rd_valid_q, rd_last_q;
    logic               wr_fire, rd_fire;
    logic               arb_found;
    logic [SID_W-1:0]   arb_sel, cand;

    function automatic logic [ADDR_WIDTH-1:0] region_base(input logic [SID_W-1:0] sid);
        return ADDR_WIDTH'(32'(sid) * BUFFER_SIZE);
    endfunction

    // Held in reset, the port is silent even if a write strobe is present.
    assign wr_fire = i_wr_valid & i_reset_n;

    // Round-robin: first requester after the last granted stock.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_STOCKS; k++) begin
            cand = SID_W'((32'(rr_q) + k) % NUM_STOCKS);
            if (!arb_found && i_calc_req[cand]) begin
                arb_found = 1'b1;
                arb_sel   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rd_fire = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    gnt_d = arb_sel;
                    rr_d  = arb_sel;
                    len_d = fill_q[arb_sel];
                    // A full region has wrapped, so its oldest sample sits at head.
                    idx_d = (fill_q[arb_sel] < CNT_W'(BUFFER_SIZE)) ? '0 : head_q[arb_sel];
                    state_d = (fill_q[arb_sel] != '0) ? StRead : StDone;
                end
            end
            StRead: begin
                if (!wr_fire) begin
                    rd_fire = 1'b1;
                    idx_d   = (idx_q == IDX_W'(BUFFER_SIZE - 1)) ? '0 : idx_q + IDX_W'(1);
                    len_d   = len_q - CNT_W'(1);
                    if (len_q == CNT_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            rr_q       <= SID_W'(NUM_STOCKS - 1);
            len_q      <= '0;
            idx_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            for (int i = 0; i < NUM_STOCKS; i++) begin
                head_q[i] <= '0;
                fill_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_q       <= rr_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            rd_valid_q <= rd_fire;
            rd_last_q  <= rd_fire && (len_q == CNT_W'(1));
            if (wr_fire) begin
                head_q[i_wr_stock_id] <= (head_q[i_wr_stock_id] == IDX_W'(BUFFER_SIZE - 1)) ?
                                         '0 : head_q[i_wr_stock_id] + IDX_W'(1);
                if (fill_q[i_wr_stock_id] != CNT_W'(BUFFER_SIZE)) begin
                    fill_q[i_wr_stock_id] <= fill_q[i_wr_stock_id] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        o_mem_we    = wr_fire;
        o_mem_re    = rd_fire & i_reset_n;
        o_mem_wdata = wr_fire ? i_wr_data : '0;
        o_mem_addr  = '0;
        if (wr_fire) begin
            o_mem_addr = region_base(i_wr_stock_id) + ADDR_WIDTH'(head_q[i_wr_stock_id]);
        end else if (rd_fire && i_reset_n) begin
            o_mem_addr = region_base(gnt_q) + ADDR_WIDTH'(idx_q);
        end
    end

    always_comb begin
        o_calc_ack = '0;
        for (int i = 0; i < NUM_STOCKS; i++) begin
            o_calc_ack[i] = (state_q == StDone) && (gnt_q == SID_W'(i));
        end
    end

    assign o_rd_valid    = rd_valid_q;
    assign o_rd_data     = rd_valid_q ? i_mem_rdata : '0;
    assign o_rd_last     = rd_last_q;
    assign o_rd_stock_id = gnt_q;
    assign o_busy        = (state_q != StIdle);

endmodule

// File: tb/tb_volatility_buf_sched.sv
// Directed bench for volatility_buf_sched: behavioural RAM, negedge event logger,
// hand-computed expected streams per scenario.
module tb_volatility_buf_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic [1:0]  wr_sid;
    logic [31:0] wr_data;
    logic [3:0]  calc_req;
    logic [3:0]  calc_ack;
    logic        mem_we, mem_re;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        rd_valid, rd_last, busy;
    logic [31:0] rd_data;
    logic [1:0]  rd_sid;

    logic [31:0] ram [80];
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int excl_bad = 0;

    int wr_addr_q[$], wr_data_q[$], wr_cyc_q[$], wr_re_q[$];
    int rd_addr_q[$], rd_cyc_q[$];
    int dat_q[$], last_q[$], sid_q[$], dat_cyc_q[$];
    int ack_q[$], ack_cyc_q[$];
    int exp_addr_q[$], exp_data_q[$];

    volatility_buf_sched dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_wr_valid    (wr_valid),
        .i_wr_stock_id (wr_sid),
        .i_wr_data     (wr_data),
        .i_calc_req    (calc_req),
        .o_calc_ack    (calc_ack),
        .o_mem_we      (mem_we),
        .o_mem_re      (mem_re),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata),
        .o_rd_valid    (rd_valid),
        .o_rd_data     (rd_data),
        .o_rd_stock_id (rd_sid),
        .o_rd_last     (rd_last),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we && mem_re) excl_bad++;
            if (mem_we) begin
                wr_addr_q.push_back(int'(mem_addr));
                wr_data_q.push_back(int'(mem_wdata));
                wr_cyc_q.push_back(cyc);
                wr_re_q.push_back(int'(mem_re));
            end
            if (mem_re) begin
                rd_addr_q.push_back(int'(mem_addr));
                rd_cyc_q.push_back(cyc);
            end
            if (rd_valid) begin
                dat_q.push_back(int'(rd_data));
                last_q.push_back(int'(rd_last));
                sid_q.push_back(int'(rd_sid));
                dat_cyc_q.push_back(cyc);
            end
            if (calc_ack != 4'b0) begin
                ack_q.push_back(int'(calc_ack));
                ack_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); wr_re_q.delete();
        rd_addr_q.delete(); rd_cyc_q.delete();
        dat_q.delete(); last_q.delete(); sid_q.delete(); dat_cyc_q.delete();
        ack_q.delete(); ack_cyc_q.delete();
        exp_addr_q.delete(); exp_data_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_valid = 1'b0; calc_req = 4'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic write_sample(input int sid, input int val);
        wr_valid = 1'b1;
        wr_sid   = 2'(sid);
        wr_data  = 32'(val);
        tick();
        wr_valid = 1'b0;
    endtask

    // Requester behaviour: drop a bit in the cycle after its ack.
    task automatic wait_acks(input int n, input int budget);
        int got = 0;
        int t = 0;
        while (got < n && t < budget) begin
            tick();
            t++;
            while (ack_q.size() > got) begin
                calc_req = calc_req & ~4'(ack_q[got]);
                got++;
            end
        end
        if (got < n) check("ack_timeout", got, n);
    endtask

    task automatic check_stream(input string tag, input int sid);
        int n = exp_data_q.size();
        check({tag, "_nreads"}, rd_addr_q.size(), exp_addr_q.size());
        check({tag, "_ndata"}, dat_q.size(), n);
        for (int i = 0; i < exp_addr_q.size(); i++)
            check($sformatf("%s_addr%0d", tag, i),
                  (i < rd_addr_q.size()) ? rd_addr_q[i] : -1, exp_addr_q[i]);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), (i < dat_q.size()) ? dat_q[i] : -1,
                  exp_data_q[i]);
            check($sformatf("%s_last%0d", tag, i), (i < last_q.size()) ? last_q[i] : -1,
                  (i == n - 1) ? 1 : 0);
            if (sid >= 0)
                check($sformatf("%s_sid%0d", tag, i), (i < sid_q.size()) ? sid_q[i] : -1,
                      sid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst_n = 1'b0; wr_valid = 1'b0; wr_sid = 2'b0; wr_data = 32'b0; calc_req = 4'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_mem_re", int'(mem_re), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_last", int'(rd_last), 0);
        check("rst_rd_sid", int'(rd_sid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ack", int'(calc_ack), 0);
        rst_n = 1'b1;
        tick();

        // 1: three samples into stock 1
        clear_logs();
        write_sample(1, 10); write_sample(1, 20); write_sample(1, 30);
        check("t1_nwr", wr_addr_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("t1_wr_addr%0d", i), (i < wr_addr_q.size()) ? wr_addr_q[i] : -1,
                  20 + i);
        calc_req = 4'b0010;
        c0 = cyc;
        wait_acks(1, 40);
        exp_addr_q = '{20, 21, 22};
        exp_data_q = '{10, 20, 30};
        check_stream("t1", 1);
        check("t1_ack", (ack_q.size() > 0) ? ack_q[0] : -1, 2);
        check("t1_first_data_cyc", (dat_cyc_q.size() > 0) ? dat_cyc_q[0] : -1, c0 + 2);
        check("t1_ack_cyc", (ack_cyc_q.size() > 0) ? ack_cyc_q[0] : -1,
              (dat_cyc_q.size() > 0) ? dat_cyc_q[dat_cyc_q.size() - 1] + 1 : -1);

        // 2: 23 samples into stock 0, buffer wraps
        clear_logs();
        for (int v = 1; v <= 23; v++) write_sample(0, v);
        check("t2_wr_wrap_addr", (wr_addr_q.size() > 20) ? wr_addr_q[20] : -1, 0);
        calc_req = 4'b0001;
        wait_acks(1, 60);
        for (int i = 0; i < 20; i++) begin
            exp_addr_q.push_back((3 + i) % 20);
            exp_data_q.push_back(4 + i);
        end
        check_stream("t2", 0);
        check("t2_ack", (ack_q.size() > 0) ? ack_q[0] : -1, 1);

        // 3: empty stock 2
        clear_logs();
        calc_req = 4'b0100;
        c0 = cyc;
        wait_acks(1, 20);
        check("t3_nreads", rd_addr_q.size(), 0);
        check("t3_ndata", dat_q.size(), 0);
        check("t3_ack", (ack_q.size() > 0) ? ack_q[0] : -1, 4);
        check("t3_ack_cyc", (ack_cyc_q.size() > 0) ? ack_cyc_q[0] : -1, c0 + 1);

        // 4: all four stocks, two samples each, round-robin from stock 0
        do_reset();
        clear_logs();
        for (int s = 0; s < 4; s++) begin
            write_sample(s, 10 * s + 1);
            write_sample(s, 10 * s + 2);
        end
        calc_req = 4'b1111;
        wait_acks(4, 100);
        for (int s = 0; s < 4; s++)
            check($sformatf("t4_ack%0d", s), (s < ack_q.size()) ? ack_q[s] : -1, 1 << s);
        check("t4_ndata", dat_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4_data%0d", i), (i < dat_q.size()) ? dat_q[i] : -1,
                  10 * (i / 2) + 1 + (i % 2));
            check($sformatf("t4_sid%0d", i), (i < sid_q.size()) ? sid_q[i] : -1, i / 2);
        end

        // 5: stock-3 burst of 4 with two interleaved stock-0 writes
        write_sample(3, 33); write_sample(3, 34);
        clear_logs();
        calc_req = 4'b1000;
        c0 = cyc;
        tick();
        tick();
        wr_valid = 1'b1; wr_sid = 2'd0; wr_data = 32'd101;
        tick();
        wr_valid = 1'b0;
        tick();
        wr_valid = 1'b1; wr_sid = 2'd0; wr_data = 32'd102;
        tick();
        wr_valid = 1'b0;
        wait_acks(1, 40);
        check("t5_nwr", wr_addr_q.size(), 2);
        check("t5_wr0_cyc", (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1, c0 + 2);
        check("t5_wr1_cyc", (wr_cyc_q.size() > 1) ? wr_cyc_q[1] : -1, c0 + 4);
        check("t5_wr0_addr", (wr_addr_q.size() > 0) ? wr_addr_q[0] : -1, 2);
        check("t5_wr1_addr", (wr_addr_q.size() > 1) ? wr_addr_q[1] : -1, 3);
        check("t5_wr0_re", (wr_re_q.size() > 0) ? wr_re_q[0] : -1, 0);
        check("t5_wr1_re", (wr_re_q.size() > 1) ? wr_re_q[1] : -1, 0);
        exp_addr_q = '{60, 61, 62, 63};
        exp_data_q = '{31, 32, 33, 34};
        check_stream("t5", 3);
        check("t5_ack", (ack_q.size() > 0) ? ack_q[0] : -1, 8);
        check("t5_ack_cyc", (ack_cyc_q.size() > 0) ? ack_cyc_q[0] : -1, c0 + 8);
        clear_logs();
        calc_req = 4'b0001;
        wait_acks(1, 40);
        exp_addr_q = '{0, 1, 2, 3};
        exp_data_q = '{1, 2, 101, 102};
        check_stream("t5_fill0", 0);

        // 6: reset in the middle of a 20-sample burst
        for (int i = 0; i < 20; i++) write_sample(1, 200 + i);
        clear_logs();
        calc_req = 4'b0010;
        tick(); tick(); tick(); tick();
        check("t6_busy_pre", int'(busy), 1);
        rst_n = 1'b0;
        calc_req = 4'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_rd_valid", int'(rd_valid), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_ack", int'(calc_ack), 0);
        tick();
        clear_logs();
        calc_req = 4'b0010;
        c0 = cyc;
        wait_acks(1, 20);
        check("t6_post_nreads", rd_addr_q.size(), 0);
        check("t6_post_ndata", dat_q.size(), 0);
        check("t6_post_ack", (ack_q.size() > 0) ? ack_q[0] : -1, 2);
        check("t6_post_ack_cyc", (ack_cyc_q.size() > 0) ? ack_cyc_q[0] : -1, c0 + 1);

        check("we_re_exclusive", excl_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
